// File: rtl/rib_dma.sv
// Single-outstanding word-copy DMA on RIB: register slave port for programming,
// initiator port for read-then-write copies, level interrupt on completion.
module rib_dma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_addr_i,
  input  logic [31:0] s_data_i,
  input  logic [3:0]  s_sel_i,
  input  logic        s_we_i,
  input  logic        s_req_vld_i,
  output logic        s_req_rdy_o,
  output logic        s_rsp_vld_o,
  input  logic        s_rsp_rdy_i,
  output logic [31:0] s_data_o,
  output logic [31:0] m_addr_o,
  output logic [31:0] m_data_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_req_vld_o,
  input  logic        m_req_rdy_i,
  input  logic        m_rsp_vld_i,
  output logic        m_rsp_rdy_o,
  input  logic [31:0] m_data_i,
  output logic        int_o
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP} state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d, dst_q, dst_d;
  logic [31:0]      cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
  logic [31:0]      data_q, data_d, s_rdata_q, s_rdata_d;
  logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic             done_q, done_d, int_en_q, int_en_d, abort_q, abort_d;
  logic             s_rsp_vld_q, s_rsp_vld_d;

  logic       s_acc, s_wr, busy, ctrl_wr, start, abort_req, abort_now;
  logic [1:0] reg_sel;
  logic       unused_ok;

  assign unused_ok = ^{s_sel_i, s_addr_i[31:4], s_addr_i[1:0]};

  always_comb begin
    s_acc     = s_req_vld_i && !s_rsp_vld_q;
    s_wr      = s_acc && s_we_i;
    reg_sel   = s_addr_i[3:2];
    busy      = (state_q != IDLE);
    ctrl_wr   = s_wr && (reg_sel == 2'd0);
    start     = ctrl_wr && s_data_i[0] && !busy;
    abort_req = ctrl_wr && s_data_i[4] && busy;
    abort_now = abort_q || abort_req;

    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    cur_src_d   = cur_src_q;
    cur_dst_d   = cur_dst_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    done_d      = done_q;
    int_en_d    = int_en_q;
    abort_d     = abort_q || abort_req;
    s_rsp_vld_d = s_rsp_vld_q;
    s_rdata_d   = s_rdata_q;

    if (s_rsp_vld_q && s_rsp_rdy_i) s_rsp_vld_d = 1'b0;
    if (s_acc) begin
      s_rsp_vld_d = 1'b1;
      s_rdata_d   = '0;
      if (!s_we_i) begin
        case (reg_sel)
          2'd0:    s_rdata_d = {28'd0, int_en_q, done_q, busy, 1'b0};
          2'd1:    s_rdata_d = src_q;
          2'd2:    s_rdata_d = dst_q;
          default: s_rdata_d = 32'(len_q);
        endcase
      end
    end

    if (s_wr && !busy) begin
      case (reg_sel)
        2'd1:    src_d = {s_data_i[31:2], 2'b00};
        2'd2:    dst_d = {s_data_i[31:2], 2'b00};
        2'd3:    len_d = s_data_i[LEN_W-1:0];
        default: ;
      endcase
    end
    if (ctrl_wr) begin
      int_en_d = s_data_i[3];
      if (s_data_i[2]) done_d = 1'b0;
    end

    // FSM updates follow the CTRL write so a completion set overrides a W1C clear
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_q == '0) begin
            done_d = 1'b1;
          end else begin
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            cnt_d     = len_q;
            state_d   = RD_REQ;
          end
        end
      end
      RD_REQ: if (m_req_rdy_i) state_d = RD_RSP;
      RD_RSP: begin
        if (m_rsp_vld_i) begin
          data_d  = m_data_i;
          state_d = abort_now ? IDLE : WR_REQ;
        end
      end
      WR_REQ: if (m_req_rdy_i) state_d = WR_RSP;
      WR_RSP: begin
        if (m_rsp_vld_i) begin
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = abort_now ? IDLE : RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) abort_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      int_en_q    <= 1'b0;
      abort_q     <= 1'b0;
      s_rsp_vld_q <= 1'b0;
      s_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      done_q      <= done_d;
      int_en_q    <= int_en_d;
      abort_q     <= abort_d;
      s_rsp_vld_q <= s_rsp_vld_d;
      s_rdata_q   <= s_rdata_d;
    end
  end

  always_comb begin
    m_req_vld_o = (state_q == RD_REQ) || (state_q == WR_REQ);
    m_we_o      = (state_q == WR_REQ);
    m_rsp_rdy_o = (state_q == RD_RSP) || (state_q == WR_RSP);
    m_addr_o    = '0;
    if (state_q == RD_REQ) m_addr_o = cur_src_q;
    if (state_q == WR_REQ) m_addr_o = cur_dst_q;
    m_data_o    = data_q;
    m_sel_o     = 4'hf;
    s_rsp_vld_o = s_rsp_vld_q;
    s_req_rdy_o = !s_rsp_vld_q;
    s_data_o    = s_rdata_q;
    int_o       = done_q && int_en_q;
  end

endmodule
